// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS data cache.
package mips_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;

  // Cache controller states.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FILL     = 2'd1,
    S_RMW_READ = 2'd2,
    S_WRITE    = 2'd3
  } dc_state_e;

  // Byte-lane word; lane 0 is bits 31:24, so lane i is element LANES-1-i.
  typedef logic [LANES-1:0][LANE_W-1:0] word_t;

  // Overlay the enabled lanes of data onto base; byte_en bit i selects lane i.
  function automatic word_t lane_merge(input word_t base, input word_t data,
                                       input logic [LANES-1:0] be);
    word_t r;
    r = base;
    for (int i = 0; i < int'(LANES); i++) begin
      if (be[i]) r[int'(LANES) - 1 - i] = data[int'(LANES) - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_dcache_array.sv
// Direct-mapped tag/valid/data storage: one async read port, one write port.
module mips_dcache_array
  import mips_pkg::*;
#(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned TAG_W     = 26
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output word_t            rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  word_t            wr_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  word_t                data_q [NUM_LINES];

  // Valid bits: cleared on reset, set by any line write.
  always_ff @(posedge clk) begin
    if (!rst_b) valid_q <= '0;
    else if (wr_en) valid_q[wr_idx] <= 1'b1;
  end

  // Tag and data arrays are not reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/mips_dcache.sv
// Write-through, no-write-allocate, direct-mapped one-word-line data cache.
module mips_dcache
  import mips_pkg::*;
#(
  parameter int unsigned NUM_LINES   = 16,
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_byte_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  word_t             cpu_wdata,
  output word_t             cpu_rdata,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output word_t             mem_data_in,
  output logic              mem_write_en,
  input  word_t             mem_data_out
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;
  localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(MEM_LATENCY);

  dc_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  word_t             wr_data_q;

  logic [IDX_W-1:0]  cpu_idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic [1:0]        unused_addr_lsb;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  word_t             rd_data;
  logic              hit;
  logic              full_word;
  word_t             st_merge;
  logic              arr_we;
  word_t             arr_wdata;

  assign cpu_idx         = cpu_addr[2 +: IDX_W];
  assign cpu_tag         = cpu_addr[ADDR_W-1 -: TAG_W];
  assign unused_addr_lsb = cpu_addr[1:0];
  assign hit             = rd_valid && (rd_tag == cpu_tag);
  assign full_word       = (cpu_byte_en == 4'b1111);
  // Store data merged over the cached word on a hit, over zero otherwise.
  assign st_merge        = lane_merge(hit ? rd_data : word_t'('0), cpu_wdata, cpu_byte_en);

  mips_dcache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst_b    (rst_b),
    .rd_idx   (cpu_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (arr_we),
    .wr_idx   (cpu_idx),
    .wr_tag   (cpu_tag),
    .wr_data  (arr_wdata)
  );

  // Line writes: store hits update at WRITE entry, fills on the last memory cycle.
  always_comb begin
    arr_we    = 1'b0;
    arr_wdata = mem_data_out;
    if (rst_b) begin
      if (state == S_IDLE && cpu_req && cpu_we && hit) begin
        arr_we    = 1'b1;
        arr_wdata = st_merge;
      end else if (state == S_FILL && cnt == CNT_LAST) begin
        arr_we = 1'b1;
      end
    end
  end

  // Controller FSM with the shared latency counter and write-data holding register.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            addr_q <= {cpu_addr[ADDR_W-1:2], 2'b00};
            cnt    <= '0;
            if (!cpu_we) begin
              if (!hit) state <= S_FILL;
            end else if (full_word || hit) begin
              wr_data_q <= st_merge;
              state     <= S_WRITE;
            end else begin
              state <= S_RMW_READ;
            end
          end
        end
        // Counter runs one past the latency so the ready cycle has its own slot.
        S_FILL: begin
          if (cnt == CNT_DONE) state <= S_IDLE;
          else cnt <= cnt + CNT_W'(1);
        end
        S_RMW_READ: begin
          if (cnt == CNT_LAST) begin
            wr_data_q <= lane_merge(mem_data_out, cpu_wdata, cpu_byte_en);
            cnt       <= '0;
            state     <= S_WRITE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WRITE: begin
          if (cnt == CNT_LAST) state <= S_IDLE;
          else cnt <= cnt + CNT_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state; forced quiet while reset is asserted.
  always_comb begin
    cpu_ready    = 1'b0;
    cpu_rdata    = '0;
    mem_addr     = '0;
    mem_write_en = 1'b0;
    mem_data_in  = '0;
    if (rst_b) begin
      case (state)
        S_IDLE: begin
          if (cpu_req && !cpu_we && hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = rd_data;
          end
        end
        S_FILL: begin
          mem_addr = addr_q;
          if (cnt == CNT_DONE) begin
            cpu_ready = 1'b1;
            cpu_rdata = rd_data;
          end
        end
        S_RMW_READ: mem_addr = addr_q;
        S_WRITE: begin
          mem_addr     = addr_q;
          mem_write_en = 1'b1;
          mem_data_in  = wr_data_q;
          cpu_ready    = (cnt == CNT_LAST);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dcache.sv
// Directed bench for mips_dcache with a transaction-level cache/memory model.
module tb_mips_dcache;

  localparam int L = 4;

  logic        clk;
  logic        rst_b;
  logic        cpu_req;
  logic        cpu_we;
  logic [3:0]  cpu_byte_en;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_write_en;
  logic [31:0] mem_data_out;

  int checks = 0;
  int errors = 0;

  // Reference state: backing memory plus what the cache should hold.
  logic [31:0] mem    [0:1023];
  logic        mvalid [0:15];
  logic [25:0] mtag   [0:15];
  logic [31:0] mdata  [0:15];

  mips_dcache #(.NUM_LINES(16), .MEM_LATENCY(L), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_byte_en  (cpu_byte_en),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ready    (cpu_ready),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] base, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[0]}}, {8{be[1]}}, {8{be[2]}}, {8{be[3]}}};
    return (base & ~m) | (d & m);
  endfunction

  // One CPU access, checked every cycle from request to expected completion.
  task automatic access(input logic we_i, input logic [3:0] be_i, input logic [31:0] addr_i,
                        input logic [31:0] wd_i, output int rk, output logic [31:0] rd,
                        output int wcnt, output logic [31:0] wlast);
    int          idx, widx, lat, wfirst;
    logic [25:0] tag;
    logic        hit;
    logic [31:0] wexp, rexp, waddr, aexp;
    idx    = int'(addr_i[5:2]);
    widx   = int'(addr_i[11:2]);
    tag    = addr_i[31:6];
    waddr  = {addr_i[31:2], 2'b00};
    hit    = mvalid[idx] && (mtag[idx] == tag);
    wexp   = 32'h0;
    wfirst = 0;
    rexp   = hit ? mdata[idx] : mem[widx];
    if (!we_i) begin
      lat = hit ? 0 : L + 1;
    end else if (hit || be_i == 4'hF) begin
      lat    = L;
      wfirst = 1;
      wexp   = merge(hit ? mdata[idx] : 32'h0, wd_i, be_i);
    end else begin
      lat    = 2 * L;
      wfirst = L + 1;
      wexp   = merge(mem[widx], wd_i, be_i);
    end
    rk = -1; rd = 32'h0; wcnt = 0; wlast = 32'h0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we_i; cpu_byte_en = be_i;
    cpu_addr = addr_i; cpu_wdata = wd_i; mem_data_out = mem[widx];
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      aexp = (k == 0) ? 32'h0 : waddr;
      chk($sformatf("ready@%h k%0d", addr_i, k), 32'(cpu_ready), 32'(k == lat));
      chk($sformatf("mem_addr@%h k%0d", addr_i, k), mem_addr, aexp);
      chk($sformatf("mem_we@%h k%0d", addr_i, k), 32'(mem_write_en),
          32'(wfirst != 0 && k >= wfirst));
      if (wfirst != 0 && k >= wfirst)
        chk($sformatf("mem_data_in@%h k%0d", addr_i, k), mem_data_in, wexp);
      if (k == lat && !we_i)
        chk($sformatf("rdata@%h", addr_i), cpu_rdata, rexp);
      if (cpu_ready && rk < 0) begin rk = k; rd = cpu_rdata; end
      if (mem_write_en) begin wcnt++; wlast = mem_data_in; end
      if (k < lat) @(posedge clk);
    end
    if (!we_i) begin
      if (!hit) begin mvalid[idx] = 1'b1; mtag[idx] = tag; mdata[idx] = mem[widx]; end
    end else begin
      mem[widx] = wexp;
      if (hit) mdata[idx] = wexp;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("idle ready", 32'(cpu_ready), 32'h0);
    chk("idle mem_addr", mem_addr, 32'h0);
    chk("idle mem_we", 32'(mem_write_en), 32'h0);
  endtask

  int          rk, wc;
  logic [31:0] rd, wl;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A000000 | 32'(i);
    for (int i = 0; i < 16; i++) begin mvalid[i] = 1'b0; mtag[i] = '0; mdata[i] = '0; end
    mem[32'h40 >> 2]  = 32'h11223344;
    mem[32'h44 >> 2]  = 32'h55667788;
    mem[32'h48 >> 2]  = 32'h99AABBCC;
    mem[32'h80 >> 2]  = 32'h01020304;
    mem[32'h100 >> 2] = 32'hCAFEF00D;
    mem[32'h440 >> 2] = 32'h0BADC0DE;
    rst_b = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte_en = 4'h0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; mem_data_out = 32'h0;

    // Outputs quiet while held in reset.
    repeat (3) begin
      @(negedge clk);
      chk("rst ready", 32'(cpu_ready), 32'h0);
      chk("rst mem_we", 32'(mem_write_en), 32'h0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst rdata", cpu_rdata, 32'h0);
      chk("rst mem_data_in", mem_data_in, 32'h0);
    end
    @(posedge clk); #1; rst_b = 1'b1;
    idle_cycle();

    // Cold miss then hit on 0x40.
    access(1'b0, 4'hF, 32'h40, 32'h0, rk, rd, wc, wl);
    chk("pin miss latency", 32'(rk), 32'd5);
    chk("pin miss data", rd, 32'h11223344);
    access(1'b0, 4'hF, 32'h40, 32'h0, rk, rd, wc, wl);
    chk("pin hit latency", 32'(rk), 32'd0);

    // Full-word store hit, then reload.
    access(1'b1, 4'hF, 32'h40, 32'hDEADBEEF, rk, rd, wc, wl);
    chk("pin sw write cycles", 32'(wc), 32'd4);
    chk("pin sw write data", wl, 32'hDEADBEEF);
    access(1'b0, 4'hF, 32'h40, 32'h0, rk, rd, wc, wl);
    chk("pin sw reload", rd, 32'hDEADBEEF);
    chk("pin sw reload latency", 32'(rk), 32'd0);
    idle_cycle();
    idle_cycle();

    // Partial store miss: read-modify-write, no allocate.
    access(1'b1, 4'b0100, 32'h80, 32'h0000AA00, rk, rd, wc, wl);
    chk("pin sb latency", 32'(rk), 32'd8);
    chk("pin sb write cycles", 32'(wc), 32'd4);
    chk("pin sb write data", wl, 32'h0102AA04);
    access(1'b0, 4'hF, 32'h80, 32'h0, rk, rd, wc, wl);
    chk("pin sb no-allocate", 32'(rk), 32'd5);
    chk("pin sb reload", rd, 32'h0102AA04);

    // Index aliasing between 0x40 and 0x440.
    access(1'b0, 4'hF, 32'h440, 32'h0, rk, rd, wc, wl);
    chk("pin alias miss", 32'(rk), 32'd5);
    access(1'b0, 4'hF, 32'h40, 32'h0, rk, rd, wc, wl);
    chk("pin alias evicted", 32'(rk), 32'd5);

    // Fill neighbours, then back-to-back hits with no bubble.
    access(1'b0, 4'hF, 32'h44, 32'h0, rk, rd, wc, wl);
    access(1'b0, 4'hF, 32'h48, 32'h0, rk, rd, wc, wl);
    access(1'b0, 4'hF, 32'h40, 32'h0, rk, rd, wc, wl);
    chk("pin b2b 0x40", 32'(rk), 32'd0);
    access(1'b0, 4'hF, 32'h44, 32'h0, rk, rd, wc, wl);
    chk("pin b2b 0x44", 32'(rk), 32'd0);
    access(1'b0, 4'hF, 32'h48, 32'h0, rk, rd, wc, wl);
    chk("pin b2b 0x48", 32'(rk), 32'd0);
    chk("pin b2b data", rd, 32'h99AABBCC);

    // Partial store hit, full-word store miss (no allocate).
    access(1'b1, 4'b0001, 32'h44, 32'h77000000, rk, rd, wc, wl);
    chk("pin sb hit data", wl, 32'h77667788);
    access(1'b0, 4'hF, 32'h44, 32'h0, rk, rd, wc, wl);
    access(1'b1, 4'hF, 32'h200, 32'h12345678, rk, rd, wc, wl);
    access(1'b0, 4'hF, 32'h200, 32'h0, rk, rd, wc, wl);
    chk("pin sw miss no-allocate", 32'(rk), 32'd5);

    // Reset in the second FILL cycle aborts the fill.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte_en = 4'hF; cpu_addr = 32'h100;
    mem_data_out = mem[32'h100 >> 2];
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(negedge clk);
    chk("midfill rst mem_we", 32'(mem_write_en), 32'h0);
    chk("midfill rst ready", 32'(cpu_ready), 32'h0);
    chk("midfill rst mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    rst_b = 1'b1; cpu_req = 1'b0;
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    @(negedge clk);
    chk("post rst mem_addr", mem_addr, 32'h0);
    chk("post rst ready", 32'(cpu_ready), 32'h0);
    access(1'b0, 4'hF, 32'h100, 32'h0, rk, rd, wc, wl);
    chk("pin post-rst miss", 32'(rk), 32'd5);
    chk("pin post-rst data", rd, 32'hCAFEF00D);
    access(1'b0, 4'hF, 32'h40, 32'h0, rk, rd, wc, wl);
    chk("pin rst cleared valid", 32'(rk), 32'd5);
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
